// File: rtl/rvm_divider_pkg.sv
// Shared constants and helpers for the RV32M iterative divide unit.
package rvm_divider_pkg;

    localparam int unsigned RVM_DIV_XLEN = 32;

    typedef logic [1:0] rvm_div_op_t;

    localparam rvm_div_op_t RVM_DIV_DIV  = 2'b00;
    localparam rvm_div_op_t RVM_DIV_DIVU = 2'b01;
    localparam rvm_div_op_t RVM_DIV_REM  = 2'b10;
    localparam rvm_div_op_t RVM_DIV_REMU = 2'b11;

    function automatic logic op_is_signed(rvm_div_op_t op);
        return (op == RVM_DIV_DIV) || (op == RVM_DIV_REM);
    endfunction

    function automatic logic op_is_rem(rvm_div_op_t op);
        return (op == RVM_DIV_REM) || (op == RVM_DIV_REMU);
    endfunction

endpackage

// File: rtl/rvm_divider_if.sv
// Request/response bundle between the execute-stage control FSM and the divider.
interface rvm_divider_if;

    logic                                          start;
    rvm_divider_pkg::rvm_div_op_t                  op;
    logic [rvm_divider_pkg::RVM_DIV_XLEN-1:0]      lhs;
    logic [rvm_divider_pkg::RVM_DIV_XLEN-1:0]      rhs;
    logic                                          busy;
    logic                                          done;
    logic [rvm_divider_pkg::RVM_DIV_XLEN-1:0]      result;

    modport master (
        output start,
        output op,
        output lhs,
        output rhs,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  op,
        input  lhs,
        input  rhs,
        output busy,
        output done,
        output result
    );

endinterface

// File: rtl/rvm_div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract, select.
module rvm_div_step #(
    parameter int unsigned Width = 32
) (
    input  logic [Width:0]   rem,
    input  logic [Width-1:0] quo,
    input  logic [Width-1:0] divisor,
    output logic [Width:0]   rem_next,
    output logic [Width-1:0] quo_next,
    output logic             qbit
);

    logic [Width:0]   shifted;
    logic [Width+1:0] trial;
    logic             unused_rem_msb;

    // The restored remainder is always below the divisor, so its top bit is zero.
    assign unused_rem_msb = rem[Width];

    always_comb begin
        shifted  = {rem[Width-1:0], quo[Width-1]};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        qbit     = ~trial[Width+1];
        rem_next = qbit ? trial[Width:0] : shifted;
        quo_next = {quo[Width-2:0], qbit};
    end

endmodule

// File: rtl/rvm_divider.sv
// RV32M DIV/DIVU/REM/REMU iterative divider, one quotient bit per cycle.
// Optional RVM_DIV_EARLY_OUT_EN skips the iteration loop for /0, overflow and /1.
module rvm_divider
    import rvm_divider_pkg::*;
#(
    parameter int unsigned XLEN = RVM_DIV_XLEN
) (
    input logic          clk,
    input logic          reset,
    rvm_divider_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } state_e;

    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

    state_e          state_q, state_d;
    rvm_div_op_t     op_q, op_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN-1:0] lhs_q, lhs_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            dz_q, dz_d;
    logic            ovf_q, ovf_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
`ifdef RVM_DIV_EARLY_OUT_EN
    logic            one_q, one_d;
`endif

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;
    logic            qbit_unused;
    logic            is_signed;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;

    rvm_div_step #(
        .Width (XLEN)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (step_rem),
        .quo_next (step_quo),
        .qbit     (qbit_unused)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        lhs_d     = lhs_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef RVM_DIV_EARLY_OUT_EN
        one_d     = one_q;
`endif
        is_signed = op_is_signed(bus.op);
        q_fin     = quo_q;
        r_fin     = rem_q[XLEN-1:0];

        unique case (state_q)
            StIdle: begin
                // busy_q still set here means this is the done cycle; start is ignored.
                if (bus.start && !busy_q) begin
                    op_d      = bus.op;
                    lhs_d     = bus.lhs;
                    quo_d     = (is_signed && bus.lhs[XLEN-1]) ? -bus.lhs : bus.lhs;
                    divisor_d = (is_signed && bus.rhs[XLEN-1]) ? -bus.rhs : bus.rhs;
                    qneg_d    = is_signed && (bus.lhs[XLEN-1] ^ bus.rhs[XLEN-1]);
                    rneg_d    = is_signed && bus.lhs[XLEN-1];
                    dz_d      = (bus.rhs == '0);
                    ovf_d     = is_signed && (bus.lhs == MinNeg) && (bus.rhs == AllOnes);
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StRun;
`ifdef RVM_DIV_EARLY_OUT_EN
                    one_d     = (bus.rhs == {{(XLEN-1){1'b0}}, 1'b1});
                    if (dz_d || ovf_d || one_d) begin
                        state_d = StFix;
                    end
`endif
                end else begin
                    busy_d = 1'b0;
                end
            end
            StRun: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                q_fin = qneg_q ? -quo_q : quo_q;
                r_fin = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
`ifdef RVM_DIV_EARLY_OUT_EN
                if (one_q) begin
                    q_fin = lhs_q;
                    r_fin = '0;
                end
`endif
                if (dz_q) begin
                    q_fin = AllOnes;
                    r_fin = lhs_q;
                end else if (ovf_q) begin
                    q_fin = MinNeg;
                    r_fin = '0;
                end
                result_d = op_is_rem(op_q) ? r_fin : q_fin;
                state_d  = StDone;
            end
            StDone: begin
                // done is registered, so it appears in the cycle after this one.
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            lhs_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RVM_DIV_EARLY_OUT_EN
            one_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            lhs_q     <= lhs_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RVM_DIV_EARLY_OUT_EN
            one_q     <= one_d;
`endif
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: doc/rvm_divider.md
Name: rvm_divider

Overview:
- Multi-cycle iterative 32-bit integer divide unit for the RV32M DIV/DIVU/REM/REMU instructions.
- Performs radix-2 restoring division, one quotient bit per cycle, using a trial subtraction each step.
- Sits beside the single-cycle ALU/adder in the execute stage.
- Control FSM starts it with a one-cycle start pulse, then stalls until done.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only when busy=0
- op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- lhs  in  32  dividend
- rhs  in  32  divisor
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  single-cycle pulse; result valid this cycle
- result  out  32  quotient or remainder; held until the next accepted start

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, port reset.
- Reset values: busy=0, done=0, result=0, FSM=IDLE, all internal registers 0.
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE:
  - On start, latch op.
  - Latch |lhs| and |rhs| (absolute value only for signed ops).
  - Latch quotient sign = lhs[31]^rhs[31] and remainder sign = lhs[31] (signed ops only).
  - Latch div-by-zero flag (rhs==0) and overflow flag (DIV/REM with lhs=0x80000000, rhs=0xFFFFFFFF).
  - Clear the 33-bit partial remainder; load the quotient shift register with the dividend; count=0; go to RUN.
- RUN, each cycle:
  - Shift {rem,quo} left by 1.
  - Trial = rem[32:0] - {1'b0,divisor}.
  - If no borrow: rem = trial and shift 1 into quo; else shift 0.
  - count++. After 32 iterations (count==31 step) go to FIX.
- FIX:
  - Apply signs: quotient negated if the quotient sign is set; remainder negated if the remainder sign is set.
  - Apply special cases:
    - div-by-zero: quotient = 0xFFFFFFFF, remainder = original lhs.
    - overflow: quotient = 0x80000000, remainder = 0.
  - Select by op and register into result; go to DONE.
- DONE: done=1 for exactly one cycle; return to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E34 (34 cycles). busy=1 in the same window.
- start while busy=1: ignored, with no effect on the in-flight operation.
- start in the DONE cycle: ignored; accepted only from IDLE. A back-to-back issue is therefore accepted one cycle after done.
- reset mid-operation: next cycle IDLE, busy=0, done=0, result=0; the operation is discarded.
- Operand ports need not be stable after the start cycle.
- Unsigned ops: no absolute value; signs forced 0.

Optional Feature:
- Macro: RVM_DIV_EARLY_OUT_EN.
- Defined:
  - In IDLE, if div-by-zero, overflow, or rhs==1 at start, skip RUN and go directly to FIX; done arrives 2 cycles after start.
  - rhs==1 results: quotient = lhs, remainder = 0.
- Undefined: every operation takes the full 34 cycles.
- Results are identical in both configurations; only latency differs.

Decomposition:
- Op encodings go in the shared constants file as RVM_DIV_DIV, RVM_DIV_DIVU, RVM_DIV_REM, RVM_DIV_REMU.
- FSM state encodings are local.
- One natural sub-module, rvm_div_step: purely combinational 33-bit shift / trial-subtract / select producing next rem, next quo, and the quotient bit. It is instantiated once in the top level, which holds the FSM, counter, sign and special-case logic.

Test Plan:
- DIVU lhs=100 rhs=7 → done exactly 34 cycles after start, result=14; REMU same operands → result=2; busy high for the whole window.
- DIV lhs=0xFFFFFFF9 (-7) rhs=2 → result=0xFFFFFFFD; REM → result=0xFFFFFFFF.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0xFFFFFFFB/0 → 0xFFFFFFFF.
  - REM 0xFFFFFFFB/0 → 0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Handshake: start DIVU 100/7, re-pulse start with 9/3 at cycle 5 → result=14, only one done pulse. Assert reset at cycle 10 → busy=0 and result=0 next cycle, no done.
- With RVM_DIV_EARLY_OUT_EN: DIVU 5/0 → done 2 cycles after start, result 0xFFFFFFFF. DIV 0x12345678/1 → 2 cycles, result 0x12345678. DIVU 100/7 still takes 34 cycles.
